// File: rtl/ps2_host_tx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_pkg
// Shared definitions for the PS/2 host-side blocks: FSM state encoding,
// frame length, default timing constants and the parity helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ps2_host_tx_pkg;

   // Host transmitter FSM states
   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StInhibit = 3'd1,
      StReq     = 3'd2,
      StShift   = 3'd3,
      StWaitRel = 3'd4
   } state_e;

   // Number of device clock falls in one host-to-device frame:
   // 8 data + parity + stop + ACK
   localparam int FRAME_FALLS = 11;

   // Default timings for a 100 MHz system clock
   localparam int DEFAULT_INHIBIT_CYCLES = 12000;
   localparam int DEFAULT_FILTER_LEN     = 19;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1500000;
   localparam int DEFAULT_CNT_W          = 21;

   // Odd parity: the parity bit makes the total count of ones odd
   function automatic logic oddParity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_line_filter
// Brings one raw asynchronous PS/2 line into the clk_i domain and removes
// short glitches. The filtered output only follows the synchronised input
// once it has shown the new level for FILTER_LEN consecutive samples.
// Shared by the host transmitter and the keyboard receiver.
// Ports:
//   clk_i   system clock
//   rst_ni  synchronous active-low reset (output resets to 1 = idle line)
//   line_i  raw PS/2 line (asynchronous)
//   filt_o  synchronised, debounced line level
// ---------------------------------------------------------------------------
module ps2_host_tx_line_filter
   import ps2_host_tx_pkg::*;
#(
   parameter int FILTER_LEN = DEFAULT_FILTER_LEN
)(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic line_i,
   output logic filt_o
);

   localparam int CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic            sync1_q;
   logic            sync2_q;
   logic            filt_q;
   logic [CntW-1:0] cnt_q;

   // Two-flop synchroniser followed by a run-length filter. The counter
   // tracks how many consecutive samples have disagreed with the current
   // filtered level; any agreeing sample restarts the run, so a pulse
   // shorter than FILTER_LEN samples never reaches the output. Idle PS/2
   // lines are high, hence the reset value of 1 throughout.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= line_i;
         sync2_q <= sync1_q;
         if (sync2_q != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
               filt_q <= sync2_q;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + CntW'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard:
// inhibits the clock, issues request-to-send, shifts 8 data bits LSB first
// plus odd parity and stop on the device's clock falls, then samples the
// device ACK. Lines are open-drain: *_oe_o = 1 pulls the line low.
// Ports:
//   clk_i       system clock (100 MHz)
//   rst_ni      synchronous active-low reset
//   tx_data_i   command byte, sampled only when accepted
//   tx_valid_i  send request; accepted when tx_valid_i & tx_ready_o
//   tx_ready_o  high only while idle
//   kclk_i      raw PS/2 clock line
//   kdata_i     raw PS/2 data line
//   kclk_oe_o   1 = pull PS/2 clock low
//   kdata_oe_o  1 = pull PS/2 data low
//   busy_o      high whenever not idle (receiver ignores the bus then)
//   done_o      one-cycle pulse: byte sent and ACK sampled
//   nack_o      one-cycle pulse with done_o when the ACK bit was 1
//   err_o       one-cycle pulse on timeout (no done_o in that case)
// ---------------------------------------------------------------------------
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
   parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEFAULT_CNT_W
)(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   input  logic       kclk_i,
   input  logic       kdata_i,
   output logic       kclk_oe_o,
   output logic       kdata_oe_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       nack_o,
   output logic       err_o
);

   logic             kclkFilt;
   logic             kdataFilt;
   logic             kclkFall;
   logic             kclkPrev_q;

   state_e           state_q;
   logic [CNT_W-1:0] timer_q;
   logic [CNT_W-1:0] timerNext_d;
   logic [3:0]       bitCnt_q;
   logic [8:0]       sh_q;
   logic             ack_q;
   logic             kclkOe_q;
   logic             kdataOe_q;
   logic             busy_q;
   logic             txReady_q;
   logic             done_q;
   logic             nack_q;
   logic             err_q;

   ps2_host_tx_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_kclkFilter (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .line_i(kclk_i),
      .filt_o(kclkFilt)
   );

   ps2_host_tx_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_kdataFilter (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .line_i(kdata_i),
      .filt_o(kdataFilt)
   );

   // Falling edge of the filtered device clock, one cycle wide
   assign kclkFall = kclkPrev_q & ~kclkFilt;

   // The timer saturates so a stuck device can never wrap it back into range
   assign timerNext_d = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

   // Main FSM with every output registered. The done/err pulses are raised
   // while the FSM is still busy and the return to idle happens on the
   // following edge; this is what keeps a request presented during the
   // pulse cycle from being accepted until one cycle later.
   // During inhibit, data is pulled low one cycle before the clock is let
   // go, so the device sees the start bit already present at release.
   // In SHIFT, bitCnt_q holds the number of falls seen before the current
   // one: falls 1..9 put out data then parity (inverted, since oe=1 means
   // low), fall 10 releases data for the stop bit, fall 11 samples ACK.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         kclkPrev_q <= 1'b1;
         state_q    <= StIdle;
         timer_q    <= '0;
         bitCnt_q   <= '0;
         sh_q       <= '0;
         ack_q      <= 1'b0;
         kclkOe_q   <= 1'b0;
         kdataOe_q  <= 1'b0;
         busy_q     <= 1'b0;
         txReady_q  <= 1'b1;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         kclkPrev_q <= kclkFilt;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
         err_q      <= 1'b0;

         if (state_q != StIdle && (done_q || err_q)) begin
            state_q   <= StIdle;
            kclkOe_q  <= 1'b0;
            kdataOe_q <= 1'b0;
            busy_q    <= 1'b0;
            txReady_q <= 1'b1;
         end else begin
            case (state_q)
               StIdle: begin
                  if (tx_valid_i && txReady_q) begin
                     sh_q      <= {oddParity(tx_data_i), tx_data_i};
                     timer_q   <= '0;
                     state_q   <= StInhibit;
                     kclkOe_q  <= 1'b1;
                     busy_q    <= 1'b1;
                     txReady_q <= 1'b0;
                  end
               end

               StInhibit: begin
                  timer_q <= timerNext_d;
                  if (timer_q == CNT_W'(INHIBIT_CYCLES - 2)) begin
                     kdataOe_q <= 1'b1;
                  end
                  if (timer_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                     state_q   <= StReq;
                     timer_q   <= '0;
                     kclkOe_q  <= 1'b0;
                     kdataOe_q <= 1'b1;
                  end
               end

               StReq: begin
                  timer_q <= timerNext_d;
                  if (timer_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                     err_q     <= 1'b1;
                     kclkOe_q  <= 1'b0;
                     kdataOe_q <= 1'b0;
                  end else begin
                     bitCnt_q <= '0;
                     state_q  <= StShift;
                  end
               end

               StShift: begin
                  timer_q <= timerNext_d;
                  if (timer_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                     err_q     <= 1'b1;
                     kclkOe_q  <= 1'b0;
                     kdataOe_q <= 1'b0;
                  end else if (kclkFall) begin
                     bitCnt_q <= bitCnt_q + 4'd1;
                     if (bitCnt_q < 4'(FRAME_FALLS - 2)) begin
                        kdataOe_q <= ~sh_q[0];
                        sh_q      <= {1'b0, sh_q[8:1]};
                     end else if (bitCnt_q == 4'(FRAME_FALLS - 2)) begin
                        kdataOe_q <= 1'b0;
                     end else begin
                        ack_q     <= kdataFilt;
                        kdataOe_q <= 1'b0;
                        state_q   <= StWaitRel;
                     end
                  end
               end

               StWaitRel: begin
                  timer_q <= timerNext_d;
                  if (timer_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                     err_q     <= 1'b1;
                     kclkOe_q  <= 1'b0;
                     kdataOe_q <= 1'b0;
                  end else if (kclkFilt && kdataFilt) begin
                     done_q <= 1'b1;
                     nack_q <= ack_q;
                  end
               end

               default: begin
                  state_q   <= StIdle;
                  kclkOe_q  <= 1'b0;
                  kdataOe_q <= 1'b0;
                  busy_q    <= 1'b0;
                  txReady_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign tx_ready_o = txReady_q;
   assign kclk_oe_o  = kclkOe_q;
   assign kdata_oe_o = kdataOe_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign nack_o     = nack_q;
   assign err_o      = err_q;

endmodule
